// File: rtl/serial_byte_receiver.sv
// rtl/serial_byte_receiver.sv - framed serial-in, parallel-out byte receiver with valid/ack hold
// Optional even-parity check: define SERIAL_RX_PARITY_CHECK_EN (adds a PARITY state, 11-bit frame).
module serial_byte_receiver #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic serial_in,
  input  logic ack,
  output logic out1,
  output logic out2,
  output logic out3,
  output logic out4,
  output logic out5,
  output logic out6,
  output logic out7,
  output logic out8,
  output logic valid,
  output logic frame_error,
  output logic overrun,
  output logic busy
);

  typedef enum logic [2:0] {
`ifdef SERIAL_RX_PARITY_CHECK_EN
    PARITY = 3'd4,
`endif
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
  } state_t;

  // Counter compare points: mid start bit, and end of a full bit period.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic             rx_meta;
  logic             rx;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       held;
  logic             done_pend;
  logic             err_pend;
`ifdef SERIAL_RX_PARITY_CHECK_EN
  logic             par_bit;
`endif

  assign out1 = held[0];
  assign out2 = held[1];
  assign out3 = held[2];
  assign out4 = held[3];
  assign out5 = held[4];
  assign out6 = held[5];
  assign out7 = held[6];
  assign out8 = held[7];

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
    end else begin
      rx_meta <= serial_in;
      rx      <= rx_meta;
    end
  end

  // Frame FSM: finds the start bit, samples data mid-bit, and posts a one-cycle completion to the output stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      busy      <= 1'b0;
      done_pend <= 1'b0;
      err_pend  <= 1'b0;
`ifdef SERIAL_RX_PARITY_CHECK_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      done_pend <= 1'b0;
      err_pend  <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt == FULL_LAST) begin
            cnt            <= '0;
            shift[bit_idx] <= rx;
            if (bit_idx == 3'd7) begin
`ifdef SERIAL_RX_PARITY_CHECK_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
`ifdef SERIAL_RX_PARITY_CHECK_EN
        PARITY: begin
          if (cnt == FULL_LAST) begin
            cnt     <= '0;
            par_bit <= rx;
            state   <= STOP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
`endif
        STOP: begin
          if (cnt == FULL_LAST) begin
            cnt       <= '0;
            state     <= IDLE;
            busy      <= 1'b0;
            done_pend <= 1'b1;
`ifdef SERIAL_RX_PARITY_CHECK_EN
            // Even parity: data ones plus parity bit must be even.
            err_pend  <= !rx || (par_bit != ^shift);
`else
            err_pend  <= !rx;
`endif
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: loads completed bytes, runs the valid/ack handshake, flags frame and overrun errors.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      held        <= '0;
      valid       <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= done_pend && err_pend;
      if (done_pend && !err_pend) begin
        if (!valid || ack) begin
          // Free slot, or the consumer takes the old byte this very cycle.
          held  <= shift;
          valid <= 1'b1;
          if (valid) begin
            overrun <= 1'b0;
          end
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ack) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_byte_receiver.sv
// tb/tb_serial_byte_receiver.sv - directed bench with a frame-level scoreboard model for serial_byte_receiver
module tb_serial_byte_receiver;

  localparam int CPB = 4;
`ifdef SERIAL_RX_PARITY_CHECK_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Output update edge counted from the edge after which the start bit is driven.
  localparam int RESOLVE = FRAME_BITS * CPB + 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic serial_in = 1'b1;
  logic ack = 1'b0;
  logic out1, out2, out3, out4, out5, out6, out7, out8;
  logic valid, frame_error, overrun, busy;
  logic [7:0] got;

  assign got = {out8, out7, out6, out5, out4, out3, out2, out1};

  serial_byte_receiver #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .serial_in(serial_in), .ack(ack),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4),
    .out5(out5), .out6(out6), .out7(out7), .out8(out8),
    .valid(valid), .frame_error(frame_error), .overrun(overrun), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ferr_seen = 0;
  int ev_at[64];
  logic [7:0] ev_data[64];
  logic ev_good[64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic [7:0] exp_out = 8'h00;
  logic exp_valid = 1'b0;
  logic exp_ov = 1'b0;
  logic exp_ferr = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; drives one frame and posts its expected outcome.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip, input logic ack_done);
    ev_at[wr_ptr]   = cyc + RESOLVE;
    ev_data[wr_ptr] = d;
`ifdef SERIAL_RX_PARITY_CHECK_EN
    ev_good[wr_ptr] = stop && !par_flip;
`else
    ev_good[wr_ptr] = stop;
`endif
    wr_ptr++;
    serial_in = 1'b0;
    repeat (CPB) @(posedge clock);
    #1;
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      repeat (CPB) @(posedge clock);
      #1;
    end
`ifdef SERIAL_RX_PARITY_CHECK_EN
    serial_in = (^d) ^ par_flip;
    repeat (CPB) @(posedge clock);
    #1;
`endif
    serial_in = stop;
    repeat (CPB) @(posedge clock);
    #1;
    serial_in = 1'b1;
    if (ack_done) begin
      fork
        begin
          @(posedge clock);
          #1 ack = 1'b1;
          @(posedge clock);
          #1 ack = 1'b0;
        end
      join_none
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clock);
    #1 ack = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int f0;
    fork
      // Frame-level model: applies each posted frame outcome and the ack rules at the edge they take effect.
      forever begin
        @(posedge clock or negedge reset_n);
        if (!reset_n) begin
          cyc = 0;
          exp_out = 8'h00;
          exp_valid = 1'b0;
          exp_ov = 1'b0;
          exp_ferr = 1'b0;
          rd_ptr = wr_ptr;
        end else begin
          logic hit;
          cyc++;
          exp_ferr = 1'b0;
          hit = (rd_ptr != wr_ptr) && (ev_at[rd_ptr] == cyc);
          if (hit && !ev_good[rd_ptr]) exp_ferr = 1'b1;
          if (hit && ev_good[rd_ptr]) begin
            if (!exp_valid || ack) begin
              if (exp_valid) exp_ov = 1'b0;
              exp_out = ev_data[rd_ptr];
              exp_valid = 1'b1;
            end else begin
              exp_ov = 1'b1;
            end
          end else if (ack && exp_valid) begin
            exp_valid = 1'b0;
            exp_ov = 1'b0;
          end
          if (hit) rd_ptr++;
        end
      end
      // Per-cycle comparison against the model.
      forever begin
        @(negedge clock);
        if (reset_n) begin
          check("m_out", int'(got), int'(exp_out));
          check("m_valid", int'(valid), int'(exp_valid));
          check("m_overrun", int'(overrun), int'(exp_ov));
          check("m_frame_error", int'(frame_error), int'(exp_ferr));
          if (frame_error) ferr_seen++;
        end
      end
    join_none

    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    wait_cycles(20);
    check("rst_busy", int'(busy), 0);
    check("rst_out", int'(got), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_frame_error", int'(frame_error), 0);

    // 0xA5 good frame, then ack
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    wait_cycles(4);
    check("a5_out", int'(got), 'hA5);
    check("a5_valid", int'(valid), 1);
    do_ack();
    wait_cycles(2);
    check("a5_ack_valid", int'(valid), 0);
    check("a5_ack_hold", int'(got), 'hA5);

    // 0x3C with bad stop bit
    f0 = ferr_seen;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_cycles(4);
    check("bad_stop_pulses", ferr_seen - f0, 1);
    check("bad_stop_valid", int'(valid), 0);
    check("bad_stop_out", int'(got), 'hA5);

    // one-clock low glitch
    f0 = ferr_seen;
    serial_in = 1'b0;
    wait_cycles(1);
    serial_in = 1'b1;
    wait_cycles(10);
    check("glitch_busy", int'(busy), 0);
    check("glitch_valid", int'(valid), 0);
    check("glitch_pulses", ferr_seen - f0, 0);

    // overrun: 0x11 held, 0x22 dropped
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    wait_cycles(4);
    check("ovr_out", int'(got), 'h11);
    check("ovr_flag", int'(overrun), 1);
    check("ovr_valid", int'(valid), 1);
    do_ack();
    wait_cycles(2);
    check("ovr_ack_flag", int'(overrun), 0);
    check("ovr_ack_valid", int'(valid), 0);

    // 0x55 held, ack lands on the 0x77 completion cycle
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    send_frame(8'h77, 1'b1, 1'b0, 1'b1);
    wait_cycles(4);
    check("same_cycle_out", int'(got), 'h77);
    check("same_cycle_valid", int'(valid), 1);
    check("same_cycle_overrun", int'(overrun), 0);

    // reset in the middle of DATA
    serial_in = 1'b0;
    wait_cycles(CPB);
    serial_in = 1'b1;
    wait_cycles(2 * CPB);
    check("mid_busy", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_out", int'(got), 0);
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_overrun", int'(overrun), 0);
    check("mid_rst_frame_error", int'(frame_error), 0);
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(10);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_valid", int'(valid), 0);

`ifdef SERIAL_RX_PARITY_CHECK_EN
    f0 = ferr_seen;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    wait_cycles(4);
    check("par_bad_pulses", ferr_seen - f0, 1);
    check("par_bad_valid", int'(valid), 0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    wait_cycles(4);
    check("par_good_valid", int'(valid), 1);
    check("par_good_out", int'(got), 'h07);
`endif

    wait_cycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
